// File: rtl/one_hot_seq_monitor.sv
// ============================================================================
// Module  : one_hot_seq_monitor
// Brief   : Checks a one-hot upstream sequencer (IDLE->S1->S2->S3->IDLE) and
//           its output code, counts laps, and flags sticky errors.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module one_hot_seq_monitor #(
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state_in,
  input  logic [1:0]       out_in,
  input  logic             valid_in,
  input  logic             clr_err,
  output logic             locked,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             lap_pulse,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_out,
  output logic             err_any
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_TRACK    = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam logic [3:0]       C_IDLE    = 4'b0001;
  localparam logic [3:0]       C_S3      = 4'b1000;
  localparam logic [LAP_W-1:0] C_LAP_MAX = '1;

  logic [1:0]       r_state, w_state_nxt;
  logic [3:0]       r_prev, w_prev_nxt;
  logic [LAP_W-1:0] r_lap_cnt, w_lap_cnt_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_lap_pulse, w_lap_pulse_nxt;
  logic             r_err_onehot, w_err_onehot_nxt;
  logic             r_err_seq, w_err_seq_nxt;
  logic             r_err_out, w_err_out_nxt;
  logic             r_err_any, w_err_any_nxt;

  logic             w_onehot;
  logic [3:0]       w_succ;
  logic [1:0]       w_prev_idx;
  logic             w_bad_oh, w_bad_seq, w_bad_out, w_fail, w_lap;

  assign w_onehot  = (state_in != 4'd0) && ((state_in & (state_in - 4'd1)) == 4'd0);
  assign w_succ    = {r_prev[2:0], r_prev[3]};
  assign w_bad_oh  = !w_onehot;
  assign w_bad_seq = (state_in != w_succ);
  assign w_bad_out = (out_in != w_prev_idx);
  assign w_fail    = w_bad_oh | w_bad_seq | w_bad_out;
  assign w_lap     = (r_prev == C_S3) && (state_in == C_IDLE);

  // r_prev is always one-hot, so the default arm only ever decodes IDLE.
  always_comb begin
    w_prev_idx = 2'd0;
    case (r_prev)
      4'b0010: w_prev_idx = 2'd1;
      4'b0100: w_prev_idx = 2'd2;
      4'b1000: w_prev_idx = 2'd3;
      default: w_prev_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_UNLOCKED;
      r_prev       <= C_IDLE;
      r_lap_cnt    <= '0;
      r_locked     <= 1'b0;
      r_lap_pulse  <= 1'b0;
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_out    <= 1'b0;
      r_err_any    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_lap_cnt    <= w_lap_cnt_nxt;
      r_locked     <= w_locked_nxt;
      r_lap_pulse  <= w_lap_pulse_nxt;
      r_err_onehot <= w_err_onehot_nxt;
      r_err_seq    <= w_err_seq_nxt;
      r_err_out    <= w_err_out_nxt;
      r_err_any    <= w_err_any_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr_err) begin
      w_state_nxt = ST_UNLOCKED;
    end else if (valid_in) begin
      case (r_state)
        ST_UNLOCKED: w_state_nxt = w_onehot ? ST_TRACK : ST_FAULT;
        ST_TRACK:    w_state_nxt = w_fail ? ST_FAULT : ST_TRACK;
        ST_FAULT:    w_state_nxt = ST_FAULT;
        default:     w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // Next values for every registered output; clr_err outranks the sample.
  always_comb begin
    w_prev_nxt       = r_prev;
    w_lap_cnt_nxt    = r_lap_cnt;
    w_locked_nxt     = r_locked;
    w_lap_pulse_nxt  = 1'b0;
    w_err_onehot_nxt = r_err_onehot;
    w_err_seq_nxt    = r_err_seq;
    w_err_out_nxt    = r_err_out;
    if (clr_err) begin
      w_locked_nxt     = 1'b0;
      w_err_onehot_nxt = 1'b0;
      w_err_seq_nxt    = 1'b0;
      w_err_out_nxt    = 1'b0;
    end else if (valid_in) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_onehot) begin
            w_prev_nxt   = state_in;
            w_locked_nxt = 1'b1;
          end else begin
            w_err_onehot_nxt = 1'b1;
          end
        end
        ST_TRACK: begin
          if (w_fail) begin
            w_locked_nxt     = 1'b0;
            w_err_onehot_nxt = r_err_onehot | w_bad_oh;
            w_err_seq_nxt    = r_err_seq | w_bad_seq;
            w_err_out_nxt    = r_err_out | w_bad_out;
          end else begin
            w_prev_nxt = state_in;
            if (w_lap) begin
              w_lap_pulse_nxt = 1'b1;
              if (r_lap_cnt != C_LAP_MAX) begin
                w_lap_cnt_nxt = r_lap_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          w_locked_nxt = 1'b0;
        end
      endcase
    end
    w_err_any_nxt = w_err_onehot_nxt | w_err_seq_nxt | w_err_out_nxt;
  end

  assign locked     = r_locked;
  assign lap_cnt    = r_lap_cnt;
  assign lap_pulse  = r_lap_pulse;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;
  assign err_out    = r_err_out;
  assign err_any    = r_err_any;

endmodule

`default_nettype wire

// File: tb/tb_one_hot_seq_monitor.sv
// ============================================================================
// Module  : tb_one_hot_seq_monitor
// Brief   : Directed and random stimulus for one_hot_seq_monitor (LAP_W=8 and
//           LAP_W=2 instances) against an index-arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_one_hot_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_in;
  logic [1:0] out_in;
  logic       valid_in;
  logic       clr_err;

  logic       a_locked, a_lap_pulse, a_err_onehot, a_err_seq, a_err_out, a_err_any;
  logic [7:0] a_lap_cnt;
  logic       b_locked, b_lap_pulse, b_err_onehot, b_err_seq, b_err_out, b_err_any;
  logic [1:0] b_lap_cnt;

  always #5 clk = ~clk;

  one_hot_seq_monitor #(.LAP_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .state_in(state_in), .out_in(out_in),
    .valid_in(valid_in), .clr_err(clr_err), .locked(a_locked),
    .lap_cnt(a_lap_cnt), .lap_pulse(a_lap_pulse), .err_onehot(a_err_onehot),
    .err_seq(a_err_seq), .err_out(a_err_out), .err_any(a_err_any)
  );

  one_hot_seq_monitor #(.LAP_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .state_in(state_in), .out_in(out_in),
    .valid_in(valid_in), .clr_err(clr_err), .locked(b_locked),
    .lap_cnt(b_lap_cnt), .lap_pulse(b_lap_pulse), .err_onehot(b_err_onehot),
    .err_seq(b_err_seq), .err_out(b_err_out), .err_any(b_err_any)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses2  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the cycle as an integer 0..3, laps as an
  // unbounded count that is clamped per instance width.
  bit m_tracking, m_fault, m_pulse, m_eoh, m_eseq, m_eout;
  int m_pidx, m_laps;

  function automatic int clamp(input int laps, input int w);
    return (laps > (1 << w) - 1) ? (1 << w) - 1 : laps;
  endfunction

  task automatic model_reset();
    m_tracking = 0; m_fault = 0; m_pulse = 0;
    m_eoh = 0; m_eseq = 0; m_eout = 0;
    m_pidx = 0; m_laps = 0;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] s, input logic [1:0] o, input bit c);
    int  nidx;
    bit  b_oh, b_seq, b_out;
    m_pulse = 0;
    nidx = 0;
    for (int k = 0; k < 4; k++) if (s[k]) nidx = k;
    if (c) begin
      m_eoh = 0; m_eseq = 0; m_eout = 0;
      m_tracking = 0; m_fault = 0;
    end else if (v && !m_fault) begin
      if (!m_tracking) begin
        if ($countones(s) == 1) begin
          m_pidx = nidx; m_tracking = 1;
        end else begin
          m_eoh = 1; m_fault = 1;
        end
      end else begin
        b_oh  = ($countones(s) != 1);
        b_seq = b_oh || (nidx != (m_pidx + 1) % 4);
        b_out = (int'(o) != m_pidx);
        if (b_oh || b_seq || b_out) begin
          m_eoh |= b_oh; m_eseq |= b_seq; m_eout |= b_out;
          m_fault = 1; m_tracking = 0;
        end else begin
          if (m_pidx == 3 && nidx == 0) begin
            m_laps++; m_pulse = 1;
          end
          m_pidx = nidx;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit any;
    any = m_eoh | m_eseq | m_eout;
    check_eq({tag, ".locked8"},  a_locked,     m_tracking);
    check_eq({tag, ".lap8"},     a_lap_cnt,    clamp(m_laps, 8));
    check_eq({tag, ".pulse8"},   a_lap_pulse,  m_pulse);
    check_eq({tag, ".eoh8"},     a_err_onehot, m_eoh);
    check_eq({tag, ".eseq8"},    a_err_seq,    m_eseq);
    check_eq({tag, ".eout8"},    a_err_out,    m_eout);
    check_eq({tag, ".eany8"},    a_err_any,    any);
    check_eq({tag, ".locked2"},  b_locked,     m_tracking);
    check_eq({tag, ".lap2"},     b_lap_cnt,    clamp(m_laps, 2));
    check_eq({tag, ".pulse2"},   b_lap_pulse,  m_pulse);
    check_eq({tag, ".eany2"},    {b_err_onehot, b_err_seq, b_err_out, b_err_any},
             {m_eoh, m_eseq, m_eout, any});
  endtask

  task automatic step(input bit v, input logic [3:0] s, input logic [1:0] o, input bit c);
    valid_in = v; state_in = s; out_in = o; clr_err = c;
    @(posedge clk);
    model_edge(v, s, o, c);
    #1;
    check_all("step");
    if (b_lap_pulse === 1'b1) pulses2++;
  endtask

  task automatic legal();
    step(1'b1, 4'(1 << ((m_pidx + 1) % 4)), 2'(m_pidx), 1'b0);
  endtask

  // Called at posedge+1: pulls reset low between edges and checks at once.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_hold");
    #2 rst = 1'b1;
  endtask

  initial begin
    bit         v, c;
    logic [3:0] s;
    logic [1:0] o;
    rst = 1'b1; valid_in = 1'b0; clr_err = 1'b0; state_in = 4'd0; out_in = 2'd0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    #2 rst = 1'b1;

    // Full legal lap from reset.
    step(1, 4'b0001, 2'b00, 0);
    check_eq("lock_first_edge", a_locked, 1);
    step(1, 4'b0010, 2'b00, 0);
    step(1, 4'b0100, 2'b01, 0);
    step(1, 4'b1000, 2'b10, 0);
    step(1, 4'b0001, 2'b11, 0);
    check_eq("one_lap_cnt", a_lap_cnt, 1);
    check_eq("one_lap_pulse", a_lap_pulse, 1);

    // Four more laps: the 2-bit counter saturates at 3 but still pulses.
    for (int l = 0; l < 16; l++) legal();
    check_eq("sat2_cnt", b_lap_cnt, 3);
    check_eq("sat2_pulses", pulses2, 5);
    check_eq("cnt8_five", a_lap_cnt, 5);

    // Non-one-hot from S1, then legal samples are ignored in FAULT.
    legal();
    step(1, 4'b0110, 2'b01, 0);
    check_eq("eoh_set", a_err_onehot, 1);
    for (int l = 0; l < 6; l++) legal();
    check_eq("fault_lap_hold", a_lap_cnt, 5);

    // clr_err beats an illegal sample on the same edge; then relock.
    step(1, 4'b0110, 2'b11, 1);
    step(1, 4'b0001, 2'b00, 0);
    check_eq("relock", a_locked, 1);

    // Sequence error only, then output-code error only, both from S1.
    legal();
    step(1, 4'b1000, 2'b01, 0);
    step(0, 4'b0000, 2'b00, 1);
    step(1, 4'b0010, 2'b00, 0);
    step(1, 4'b0100, 2'b11, 0);
    check_eq("eout_only", {a_err_onehot, a_err_seq, a_err_out}, 3'b001);

    // Idle cycles with junk inputs, repeated state, then async reset mid-lap.
    step(0, 4'b0000, 2'b00, 1);
    step(1, 4'b0100, 2'b10, 0);
    for (int l = 0; l < 3; l++) step(0, 4'($urandom), 2'($urandom), 0);
    step(1, 4'b0100, 2'b10, 0);
    step(0, 4'b0000, 2'b00, 1);
    step(1, 4'b1000, 2'b00, 0);
    legal();
    reset_mid();

    // Drive the 8-bit counter into saturation.
    step(1, 4'b0001, 2'b00, 0);
    for (int l = 0; l < 4 * 258; l++) legal();
    check_eq("sat8_cnt", a_lap_cnt, 255);
    reset_mid();

    for (int i = 0; i < 2000; i++) begin
      c = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 80) begin
        s = 4'(1 << ((m_pidx + 1) % 4));
        o = 2'(m_pidx);
      end else begin
        s = 4'($urandom);
        o = 2'($urandom);
      end
      step(v, s, o, c);
      if ($urandom_range(0, 199) == 0) reset_mid();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
